// File: rtl/inhibit_gate_array_pkg.sv
// rtl/inhibit_gate_array_pkg.sv - shared types and constants for the inhibit gate array
//
// Purpose : per-channel debounce state encoding, channel limit and qualify counter width.
// Ports   : none (package).
// Options : none here; INHIBIT_STICKY_EN is consumed by the interface, channel and top.

package inhibit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        ACTIVE
    } inh_state_t;

    localparam int MAX_NCH = 16;

    // Width of the per-channel qualify counter; covers DEB_CYCLES up to 255.
    localparam int QCNT_W = 8;

endpackage

// File: rtl/inhibit_gate_array_if.sv
// rtl/inhibit_gate_array_if.sv - bundled channel inputs and qualified outputs
//
// Purpose : groups the inhibit inputs, mode/clear controls and all per-channel outputs.
// Signals : a, b (NCH)      inhibit / enable inputs
//           deb_en, clr     debounce mode select, synchronous counter clear
//           y, rise, sat    qualified output, rising pulse, counter saturated (NCH)
//           cnt             packed counters, channel i at [i*CNT_W +: CNT_W]
//           sticky (NCH)    only when INHIBIT_STICKY_EN is defined
// Modports: master drives inputs (stimulus side), slave drives outputs (the array).

interface inhibit_gate_array_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]       a;
    logic [NCH-1:0]       b;
    logic                 deb_en;
    logic                 clr;
    logic [NCH-1:0]       y;
    logic [NCH-1:0]       rise;
    logic [NCH*CNT_W-1:0] cnt;
    logic [NCH-1:0]       sat;
`ifdef INHIBIT_STICKY_EN
    logic [NCH-1:0]       sticky;

    modport master (output a, b, deb_en, clr, input y, rise, cnt, sat, sticky);
    modport slave  (input a, b, deb_en, clr, output y, rise, cnt, sat, sticky);
`else
    modport master (output a, b, deb_en, clr, input y, rise, cnt, sat);
    modport slave  (input a, b, deb_en, clr, output y, rise, cnt, sat);
`endif
endinterface

// File: rtl/inhibit_gate_array_channel.sv
// rtl/inhibit_gate_array_channel.sv - one inhibit channel: debounce FSM, output, event counter
//
// Purpose : qualifies cond = ~a & b (directly or through IDLE/QUALIFY/ACTIVE debounce),
//           registers y and its rising pulse, and counts rises into a saturating counter.
// Ports   : i_clk, i_rst (async, active-high), i_a, i_b, i_deb_en, i_clr
//           o_y, o_rise, o_cnt (CNT_W), o_sat, o_sticky (only with INHIBIT_STICKY_EN)

module inhibit_channel
    import inhibit_pkg::*;
#(
    parameter int DEB_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_deb_en,
    input  logic             i_clr,
    output logic             o_y,
    output logic             o_rise,
    output logic [CNT_W-1:0] o_cnt,
`ifdef INHIBIT_STICKY_EN
    output logic             o_sticky,
`endif
    output logic             o_sat
);

    localparam logic [QCNT_W-1:0] C_QLAST = QCNT_W'(DEB_CYCLES - 1);

    inh_state_t          r_state;
    inh_state_t          w_state_next;
    logic [QCNT_W-1:0]   r_qcnt;
    logic [QCNT_W-1:0]   w_qcnt_next;
    logic                r_y;
    logic                w_y_next;
    logic                r_rise;
    logic                w_rise_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                r_sat;
    logic                w_cond;

    assign w_cond = ~i_a & i_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_qcnt  <= '0;
            r_y     <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_qcnt  <= w_qcnt_next;
            r_y     <= w_y_next;
            r_rise  <= w_rise_next;
            r_cnt   <= w_cnt_next;
            r_sat   <= &w_cnt_next;
        end
    end

    // Direct mode parks the FSM in IDLE, so re-enabling debounce always
    // starts a fresh qualification with y low, even if cond is already high.
    always_comb begin
        w_state_next = r_state;
        w_qcnt_next  = r_qcnt;
        w_y_next     = r_y;
        if (!i_deb_en) begin
            w_state_next = IDLE;
            w_qcnt_next  = '0;
            w_y_next     = w_cond;
        end else begin
            case (r_state)
                IDLE: begin
                    w_y_next    = 1'b0;
                    w_qcnt_next = '0;
                    if (w_cond) begin
                        if (DEB_CYCLES == 1) begin
                            w_state_next = ACTIVE;
                            w_y_next     = 1'b1;
                        end else begin
                            w_state_next = QUALIFY;
                            w_qcnt_next  = QCNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    w_y_next = 1'b0;
                    if (!w_cond) begin
                        w_state_next = IDLE;
                        w_qcnt_next  = '0;
                    end else if (r_qcnt == C_QLAST) begin
                        w_state_next = ACTIVE;
                        w_qcnt_next  = '0;
                        w_y_next     = 1'b1;
                    end else begin
                        w_qcnt_next = r_qcnt + QCNT_W'(1);
                    end
                end
                ACTIVE: begin
                    w_y_next = 1'b1;
                    if (!w_cond) begin
                        w_state_next = IDLE;
                        w_y_next     = 1'b0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_qcnt_next  = '0;
                    w_y_next     = 1'b0;
                end
            endcase
        end
    end

    // The counter advances on the same edge that raises o_rise, so a clear
    // sampled on that edge discards the event.
    always_comb begin
        w_rise_next = w_y_next & ~r_y;
        w_cnt_next  = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (w_rise_next && (r_cnt != '1)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

`ifdef INHIBIT_STICKY_EN
    logic r_sticky;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sticky <= 1'b0;
        end else if (i_clr) begin
            r_sticky <= 1'b0;
        end else if (w_rise_next) begin
            r_sticky <= 1'b1;
        end
    end

    assign o_sticky = r_sticky;
`endif

    assign o_y    = r_y;
    assign o_rise = r_rise;
    assign o_cnt  = r_cnt;
    assign o_sat  = r_sat;

endmodule

// File: rtl/inhibit_gate_array.sv
// rtl/inhibit_gate_array.sv - NCH independent registered inhibit channels (Y = ~A & B)
//
// Purpose : replicates inhibit_channel NCH times and packs per-channel results onto the bus.
// Ports   : clk, reset (async, active-high), bus (inhibit_gate_array_if.slave)
// Options : INHIBIT_STICKY_EN adds per-channel sticky event flags (bus.sticky).

module inhibit_gate_array
    import inhibit_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEB_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    inhibit_gate_array_if.slave   bus
);

    logic [NCH-1:0]       w_y;
    logic [NCH-1:0]       w_rise;
    logic [NCH-1:0]       w_sat;
    logic [NCH*CNT_W-1:0] w_cnt;
`ifdef INHIBIT_STICKY_EN
    logic [NCH-1:0]       w_sticky;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        inhibit_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .i_clk    (clk),
            .i_rst    (reset),
            .i_a      (bus.a[i]),
            .i_b      (bus.b[i]),
            .i_deb_en (bus.deb_en),
            .i_clr    (bus.clr),
            .o_y      (w_y[i]),
            .o_rise   (w_rise[i]),
            .o_cnt    (w_cnt[i*CNT_W +: CNT_W]),
`ifdef INHIBIT_STICKY_EN
            .o_sticky (w_sticky[i]),
`endif
            .o_sat    (w_sat[i])
        );
    end

    assign bus.y    = w_y;
    assign bus.rise = w_rise;
    assign bus.cnt  = w_cnt;
    assign bus.sat  = w_sat;
`ifdef INHIBIT_STICKY_EN
    assign bus.sticky = w_sticky;
`endif

endmodule

// File: tb/tb_inhibit_gate_array.sv
// tb/tb_inhibit_gate_array.sv - directed self-checking bench for inhibit_gate_array

module tb_inhibit_gate_array;
    import inhibit_pkg::*;

    localparam int NCH   = 4;
    localparam int DEB   = 3;
    localparam int CNT_W = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    inhibit_gate_array_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    inhibit_gate_array #(
        .NCH        (NCH),
        .DEB_CYCLES (DEB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return bus.cnt[ch*CNT_W +: CNT_W];
    endfunction

    // One clock edge, then settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] sat_cnt [5];
        logic             sat_flag [5];
        sat_cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        sat_flag = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        bus.a      = '0;
        bus.b      = '0;
        bus.deb_en = 1'b0;
        bus.clr    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",    bus.y,    4'b0000);
        chk("rst_rise", bus.rise, 4'b0000);
        chk("rst_cnt",  bus.cnt,  8'h00);
        chk("rst_sat",  bus.sat,  4'b0000);
        reset = 1'b0;

        // Direct mode: cond = ~a & b = 0101 after one edge
        bus.a = 4'b0000;
        bus.b = 4'b0101;
        step();
        chk("dir_y",    bus.y,    4'b0101);
        chk("dir_rise", bus.rise, 4'b0101);
        chk("dir_cnt0", cnt_of(0), 2'd1);
        chk("dir_cnt1", cnt_of(1), 2'd0);
        chk("dir_cnt2", cnt_of(2), 2'd1);
        step();
        chk("dir_rise_1cyc", bus.rise, 4'b0000);
        chk("dir_y_hold",    bus.y,    4'b0101);
        // a inhibits even when b is high
        bus.a = 4'b0100;
        step();
        chk("dir_inhibit_y", bus.y, 4'b0001);
        bus.a = 4'b0000;
        bus.b = 4'b0000;
        step();
        chk("dir_off_y", bus.y, 4'b0000);

        // Saturation on ch1 (CNT_W=2): 1,2,3,3,3
        for (int k = 0; k < 5; k++) begin
            bus.b = 4'b0010;
            step();
            chk("sat_rise1", bus.rise, 4'b0010);
            chk("sat_cnt1",  cnt_of(1), sat_cnt[k]);
            chk("sat_flag1", bus.sat[1], sat_flag[k]);
            bus.b = 4'b0000;
            step();
        end

        // Clear coincides with the edge that raises rise[2]
        bus.b   = 4'b0100;
        bus.clr = 1'b1;
        step();
        chk("clr_rise2", bus.rise, 4'b0100);
        chk("clr_y2",    bus.y,    4'b0100);
        chk("clr_cnt",   bus.cnt,  8'h00);
        chk("clr_sat",   bus.sat,  4'b0000);
`ifdef INHIBIT_STICKY_EN
        chk("clr_sticky", bus.sticky, 4'b0000);
`endif
        bus.clr = 1'b0;
        step();
        chk("clr_cnt2_after", cnt_of(2), 2'd0);
        chk("clr_y2_kept",    bus.y,     4'b0100);
        bus.b = 4'b0000;
        step();

        // Debounce: short 2-cycle pulse rejected, then 3-cycle hold qualifies
        bus.deb_en = 1'b1;
        step();
        bus.b = 4'b0001;
        step();
        chk("deb_short_y_e1", bus.y, 4'b0000);
        step();
        chk("deb_short_y_e2", bus.y, 4'b0000);
        bus.b = 4'b0000;
        step();
        chk("deb_short_y_e3", bus.y, 4'b0000);
        bus.b = 4'b0001;
        step();
        chk("deb_y_e1", bus.y, 4'b0000);
        step();
        chk("deb_y_e2", bus.y, 4'b0000);
        step();
        chk("deb_y_e3",    bus.y,     4'b0001);
        chk("deb_rise_e3", bus.rise,  4'b0001);
        chk("deb_cnt0",    cnt_of(0), 2'd1);
`ifdef INHIBIT_STICKY_EN
        chk("deb_sticky", bus.sticky, 4'b0001);
`endif
        step();
        chk("deb_rise_done", bus.rise, 4'b0000);

        // Mode switch: direct keeps y high, re-entering debounce drops and requalifies
        bus.deb_en = 1'b0;
        step();
        chk("ms_direct_y",    bus.y,    4'b0001);
        chk("ms_direct_rise", bus.rise, 4'b0000);
        bus.deb_en = 1'b1;
        step();
        chk("ms_deb_y_drop", bus.y, 4'b0000);
        step();
        chk("ms_deb_y_e2", bus.y, 4'b0000);
        step();
        chk("ms_deb_y_e3",    bus.y,     4'b0001);
        chk("ms_deb_rise_e3", bus.rise,  4'b0001);
        chk("ms_cnt0",        cnt_of(0), 2'd2);

        // Reset mid-QUALIFY on ch3 while ch0 is ACTIVE
        bus.b = 4'b1001;
        step();
        chk("rq_y_e1", bus.y, 4'b0001);
        step();
        chk("rq_y_e2", bus.y, 4'b0001);
        #3;
        reset = 1'b1;
        #1;
        chk("rq_async_y",    bus.y,    4'b0000);
        chk("rq_async_rise", bus.rise, 4'b0000);
        chk("rq_async_cnt",  bus.cnt,  8'h00);
        step();
        #3;
        reset = 1'b0;
        step();
        chk("rq_restart_e1", bus.y, 4'b0000);
        step();
        chk("rq_restart_e2", bus.y, 4'b0000);
        step();
        chk("rq_restart_e3_y",    bus.y,     4'b1001);
        chk("rq_restart_e3_rise", bus.rise,  4'b1001);
        chk("rq_restart_cnt3",    cnt_of(3), 2'd1);
        chk("rq_restart_cnt0",    cnt_of(0), 2'd1);

        // Release is immediate in debounce mode
        bus.b = 4'b0000;
        step();
        chk("deb_release_y", bus.y, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inhibit_gate_array.md
Name: inhibit_gate_array

Overview:
- N-channel registered successor of the single-bit inhibit function Y = (NOT A) AND B.
- Each channel evaluates cond[i] = ~a[i] & b[i] and qualifies it through a per-channel debounce state machine.
- Each channel drives a registered output and counts qualified assertion events.
- Sits between raw lab switch/button inputs and downstream LED/counter logic.

Parameters:
- NCH, 4: number of independent channels (1..16).
- DEB_CYCLES, 3: consecutive cycles cond must hold before y asserts when debounce is on (1..255).
- CNT_W, 8: width of each per-channel event counter.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  NCH  inhibit inputs, one per channel.
- b  input  NCH  enable inputs, one per channel.
- deb_en  input  1  1 = debounce mode, 0 = direct registered mode.
- clr  input  1  synchronous clear of all counters (and sticky flags when compiled in).
- y  output  NCH  qualified inhibit output per channel.
- rise  output  NCH  one-cycle pulse on each 0->1 transition of y[i].
- cnt  output  NCH*CNT_W  packed event counters; channel i occupies bits [i*CNT_W +: CNT_W].
- sat  output  NCH  cnt[i] has reached all-ones.

Behaviour:
- Reset (asynchronous, reset=1): y=0, rise=0, cnt=0, sat=0, every channel state=IDLE, qualify counter=0.
- cond[i] = ~a[i] & b[i]. This is the only combinational term. Every output is registered.
- Direct mode (deb_en=0): y[i] <= cond[i]. Latency is exactly 1 cycle. The state machine is held in IDLE.
- Debounce mode (deb_en=1), per-channel states IDLE, QUALIFY, ACTIVE:
  - IDLE: if cond=1, go to QUALIFY and set qcnt=1; y=0.
  - QUALIFY: if cond=0, go to IDLE. Else if qcnt==DEB_CYCLES-1, go to ACTIVE and y<=1. Else qcnt++.
  - ACTIVE: y=1. If cond=0, go to IDLE and y<=0. There is no debounce on release.
  - With DEB_CYCLES=1, the IDLE->ACTIVE transition happens directly and y rises 1 cycle after cond.
  - In general, y rises DEB_CYCLES cycles after the first cycle cond is sampled high.
- A deb_en change takes effect on the next edge:
  - Switching to 0 forces IDLE; y follows cond from then on.
  - Switching to 1 starts from IDLE with y<=0, even if cond=1.
- rise[i] <= y_next[i] & ~y[i]. It is asserted in the same cycle y[i] first reads 1 and lasts one cycle.
- Counter:
  - On each rise pulse, cnt[i] increments.
  - It saturates at 2^CNT_W-1 with no wrap; sat[i]=1 while saturated.
- clr=1: next edge cnt=0 and sat=0. clr has priority over a simultaneous increment. It does not affect y or state.
- Channels are fully independent. Simultaneous events on several channels are all counted in the same cycle.
- Reset mid-QUALIFY discards progress. After release, qualification restarts from IDLE.

Optional Feature:
- Macro: INHIBIT_STICKY_EN.
- Defined: adds output port sticky (NCH).
  - sticky[i] sets on rise[i] and holds until clr or reset.
  - If clr and rise coincide, clr wins.
  - Reset value is 0.
- Undefined: no sticky port and no sticky registers.

Decomposition:
- Package inhibit_pkg holds:
  - typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE} inh_state_t;
  - localparam MAX_NCH = 16;
  - helper constant QCNT_W = 8 (qualify counter width).
- Sub-module inhibit_channel (single channel):
  - contains the state machine, qcnt, y/rise registers, counter, sat and the optional sticky flag;
  - inhibit_gate_array instantiates it NCH times with a generate loop and packs cnt.

Test Plan:
- Direct mode, NCH=4: drive a=4'b0000, b=4'b0101 -> one cycle later y=4'b0101, rise=4'b0101 for 1 cycle, cnt[0]=cnt[2]=1.
- Debounce, DEB_CYCLES=3: hold ch0 cond=1 for 2 cycles, drop, then hold for 3 cycles -> no y on the first attempt; y[0] rises 3 cycles after the second assertion; cnt[0]=1.
- Saturation, CNT_W=2: toggle ch1 cond 5 times in direct mode -> cnt[1] goes 1,2,3,3,3; sat[1]=1 from the third event.
- Clear priority: assert clr in the same cycle as rise[2] -> cnt[2]=0 next cycle (the event is dropped); sticky[2]=0 when INHIBIT_STICKY_EN is defined.
- Reset mid-QUALIFY: assert reset asynchronously between edges while ch3 is in QUALIFY -> y, cnt and rise clear immediately; after release, a full DEB_CYCLES qualification is required again.
- Mode switch: with cond[0]=1 and y[0]=1 in direct mode, set deb_en=1 -> y[0]=0 next cycle, then y[0]=1 DEB_CYCLES cycles later with a second rise pulse; cnt[0] increments.
